// File: rtl/pixel_op_stage.sv
// Frame-pass pixel stage: streams a frame out of the source BRAM and applies a
// point or 3-tap horizontal operation, then writes the result in place-order to the destination BRAM.
module pixel_op_stage #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int THRESH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sel,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              complete
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  state_e              state_q, state_d;
  logic [1:0]          drain_q, drain_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [CW-1:0]       rd_col_q, rd_col_d;
  logic                rd_en_d;
  logic                busy_q, busy_d;
  logic                complete_q, complete_d;

  // [0] read issued, [1] rd_data valid, [2] pixel in pix_q, [3] write issued
  logic [3:0]          vld_pipe_q;
  logic [ADDR_W-1:0]   addr_pipe_q [1:3];
  logic [CW-1:0]       col_pipe_q  [1:2];
  logic [DATA_W-1:0]   pix_q, left_q, wr_data_q;

  logic [DATA_W-1:0]   l_px, r_px, result;
  logic [DATA_W+1:0]   sum;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    op_d       = op_q;
    rd_addr_d  = rd_addr_q;
    rd_col_d   = rd_col_q;
    rd_en_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = READ;
          op_d      = sel;
          rd_addr_d = '0;
          rd_col_d  = '0;
          rd_en_d   = 1'b1;
        end
      end
      READ: begin
        if (rd_addr_q == ADDR_W'(N - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          rd_en_d   = 1'b1;
          rd_addr_d = rd_addr_q + 1'b1;
          rd_col_d  = (rd_col_q == CW'(IMG_W - 1)) ? '0 : rd_col_q + 1'b1;
        end
      end
      DRAIN: begin
        // three cycles: the last pixel still needs its read, capture and write stages
        drain_d = drain_q + 1'b1;
        if (drain_q == 2'd2) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d     = (state_d == READ) || (state_d == DRAIN);
    complete_d = (state_d == DONE);
  end

  // Stage 2 sees pixel x in pix_q, x-1 in left_q and x+1 arriving on rd_data.
  assign l_px = (col_pipe_q[2] == '0)              ? pix_q : left_q;
  assign r_px = (col_pipe_q[2] == CW'(IMG_W - 1))  ? pix_q : rd_data;
  assign sum  = {2'b00, l_px} + {1'b0, pix_q, 1'b0} + {2'b00, r_px};

  always_comb begin
    result = pix_q;
    unique case (op_q)
      2'd0: result = pix_q;
      2'd1: result = ~pix_q;
      2'd2: result = (pix_q >= DATA_W'(THRESH)) ? '1 : '0;
      2'd3: result = DATA_W'(sum >> 2);
      default: result = pix_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      drain_q        <= '0;
      op_q           <= '0;
      rd_addr_q      <= '0;
      rd_col_q       <= '0;
      busy_q         <= 1'b0;
      complete_q     <= 1'b0;
      vld_pipe_q     <= '0;
      addr_pipe_q[1] <= '0;
      addr_pipe_q[2] <= '0;
      addr_pipe_q[3] <= '0;
      col_pipe_q[1]  <= '0;
      col_pipe_q[2]  <= '0;
      pix_q          <= '0;
      left_q         <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      op_q           <= op_d;
      rd_addr_q      <= rd_addr_d;
      rd_col_q       <= rd_col_d;
      busy_q         <= busy_d;
      complete_q     <= complete_d;
      vld_pipe_q     <= {vld_pipe_q[2:0], rd_en_d};
      addr_pipe_q[1] <= rd_addr_q;
      addr_pipe_q[2] <= addr_pipe_q[1];
      addr_pipe_q[3] <= addr_pipe_q[2];
      col_pipe_q[1]  <= rd_col_q;
      col_pipe_q[2]  <= col_pipe_q[1];
      pix_q          <= rd_data;
      left_q         <= pix_q;
      if (vld_pipe_q[2]) wr_data_q <= result;
    end
  end

  assign rd_en    = vld_pipe_q[0];
  assign rd_addr  = rd_addr_q;
  assign wr_en    = vld_pipe_q[3];
  assign wr_addr  = addr_pipe_q[3];
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;
  assign complete = complete_q;

endmodule

// File: tb/tb_pixel_op_stage.sv
// Scoreboard bench for pixel_op_stage on a 4x2 frame with a behavioural source BRAM.
module tb_pixel_op_stage;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int THRESH = 128;
  localparam int N      = IMG_W * IMG_H;

  localparam logic [7:0] TV_PT  [8] = '{8'h30, 8'd127, 8'd128, 8'd255, 8'd0, 8'd1, 8'hFE, 8'h80};
  localparam logic [7:0] TV_SM  [8] = '{8'd0, 8'd40, 8'd80, 8'd200, 8'd200, 8'd80, 8'd40, 8'd0};

  logic              clk = 1'b0, rst = 1'b1, start = 1'b1;
  logic [1:0]        sel = 2'd0;
  logic              rd_en, wr_en, busy, complete;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic [DATA_W-1:0] rd_data = '0, wr_data;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  typedef struct {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wr_t;
  wr_t exp_q[$];
  int  n_chk = 0, n_fail = 0;

  pixel_op_stage #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .start(start), .sel(sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .complete(complete)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] s, input int k);
    int x, l, p, r;
    p = int'(mem[k]);
    x = k % IMG_W;
    l = (x == 0) ? p : int'(mem[k-1]);
    r = (x == IMG_W - 1) ? p : int'(mem[k+1]);
    case (s)
      2'd0:    return 8'(p);
      2'd1:    return 8'(255 - p);
      2'd2:    return (p >= THRESH) ? 8'hFF : 8'h00;
      default: return 8'((l + 2 * p + r) / 4);
    endcase
  endfunction

  // mode: 0 normal, 1 start/sel disturbance in cycle 5, 2 start held into next frame, 3 reset in cycle 6
  task automatic run_frame(input logic [1:0] s, input int mode, input bit pre_started);
    wr_t w;
    for (int k = 0; k < N; k++) exp_q.push_back('{ADDR_W'(k), model(s, k)});
    if (!pre_started) begin
      @(negedge clk); start = 1'b1; sel = s;
      @(posedge clk);
    end
    #1;
    if (mode != 2) start = 1'b0;
    for (int c = 1; c <= N + 4; c++) begin
      @(negedge clk);
      if (mode == 3 && c >= 7) begin
        chk("abort_rd_en", 32'(rd_en), 0);
        chk("abort_wr_en", 32'(wr_en), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_complete", 32'(complete), 0);
        if (c == 7) rst = 1'b0;
        continue;
      end
      chk("rd_en", 32'(rd_en), 32'(c <= N));
      if (c <= N) chk("rd_addr", 32'(rd_addr), 32'(c - 1));
      chk("wr_en", 32'(wr_en), 32'(c >= 4 && c <= N + 3));
      if (wr_en) begin
        if (exp_q.size() == 0) chk("sb_empty", 1, 0);
        else begin
          w = exp_q.pop_front();
          chk("wr_addr", 32'(wr_addr), 32'(w.addr));
          chk("wr_data", 32'(wr_data), 32'(w.data));
        end
      end
      chk("busy", 32'(busy), 32'(c <= N + 3));
      chk("complete", 32'(complete), 32'(c == N + 4));
      if (mode == 1 && c == 5) begin start = 1'b1; sel = ~s; end
      if (mode == 1 && c == 6) start = 1'b0;
      if (mode == 3 && c == 6) rst = 1'b1;
    end
    if (mode == 3) exp_q.delete();
    if (mode == 2) begin
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rd_en", 32'(rd_en), 0);
      chk("idle_complete", 32'(complete), 0);
      @(posedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("rst_rd_en", 32'(rd_en), 0);
      chk("rst_wr_en", 32'(wr_en), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_complete", 32'(complete), 0);
      chk("rst_rd_addr", 32'(rd_addr), 0);
      chk("rst_wr_addr", 32'(wr_addr), 0);
      chk("rst_wr_data", 32'(wr_data), 0);
    end
    rst = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_rd_en", 32'(rd_en), 0);
      chk("idle_busy", 32'(busy), 0);
    end

    for (int k = 0; k < N; k++) mem[k] = 8'(10 * k);
    run_frame(2'd0, 0, 1'b0);

    for (int k = 0; k < N; k++) mem[k] = TV_PT[k];
    run_frame(2'd1, 0, 1'b0);
    run_frame(2'd2, 0, 1'b0);

    for (int k = 0; k < N; k++) mem[k] = TV_SM[k];
    run_frame(2'd3, 0, 1'b0);
    run_frame(2'd3, 1, 1'b0);

    for (int k = 0; k < N; k++) mem[k] = TV_PT[k];
    run_frame(2'd1, 2, 1'b0);
    run_frame(2'd1, 0, 1'b1);

    for (int k = 0; k < N; k++) mem[k] = 8'(10 * k + 3);
    run_frame(2'd0, 3, 1'b0);
    for (int k = 0; k < N; k++) mem[k] = TV_SM[k];
    run_frame(2'd3, 0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_op_stage.md
# pixel_op_stage

Streaming pixel-processing stage that sits directly downstream of the `CM` memory controller in the image pipeline. On `start` it reads a full frame from the source image BRAM, one pixel per cycle. It applies the point or 3-tap operation chosen by the controller's 2-bit `sel`, writes each result to the destination BRAM at the same address, and pulses `complete` at the end of the frame. It owns all read/write addressing and enables for the frame pass; `CM` only starts it and selects the operation.

## Interface
- `IMG_W`, 128, pixels per row (≥2)
- `IMG_H`, 128, rows per frame (≥1)
- `ADDR_W`, 14, BRAM address width; `IMG_W*IMG_H` ≤ 2^`ADDR_W`
- `DATA_W`, 8, pixel width
- `THRESH`, 128, threshold level for `sel`=2
- `clk`  in  1  single clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `start`  in  1  frame request; sampled only in IDLE
- `sel`  in  2  operation select; latched on accepted `start`
- `rd_en`  out  1  source BRAM read enable
- `rd_addr`  out  `ADDR_W`  source BRAM address
- `rd_data`  in  `DATA_W`  source BRAM data; valid exactly 1 cycle after `rd_en`
- `wr_en`  out  1  destination BRAM write enable
- `wr_addr`  out  `ADDR_W`  destination address
- `wr_data`  out  `DATA_W`  result pixel
- `busy`  out  1  frame in progress
- `complete`  out  1  one-cycle end-of-frame pulse

## Operation
- The FSM has four states: IDLE, READ, DRAIN and DONE.
  - IDLE → READ on `start`=1. `sel` is latched into `op` at that edge.
  - READ issues reads for addresses 0..N-1 (N=`IMG_W*IMG_H`) on consecutive cycles, then goes to DRAIN.
  - DRAIN lasts 3 cycles, until the last write is issued, then goes to DONE.
  - DONE lasts 1 cycle, pulses `complete`, then returns to IDLE.
- `start` is ignored outside IDLE. Changes to `sel` after acceptance have no effect on the current frame.
- Each pixel's column index is x = addr mod `IMG_W`. It is tracked with a column counter that wraps at `IMG_W`-1; no divider is used.
- Operations on pixel p (L, R = left and right neighbours in the same row):
  - `op`=0: pass, result = p.
  - `op`=1: invert, result = ~p.
  - `op`=2: threshold, result = all-ones if p ≥ `THRESH`, otherwise 0.
  - `op`=3: horizontal smooth, result = (L + 2p + R) >> 2.
    - The sum is `DATA_W`+2 bits wide and the result is truncated, with no rounding.
    - Edge replication: at x=0, L = p; at x=`IMG_W`-1, R = p.
    - Neighbours never cross a row boundary.
- `wr_addr` equals the read address of the same pixel, so the output is in place-order.
- All outputs are registered.

## Timing
- Reset (`rst`=1 at an edge):
  - The FSM goes to IDLE.
  - `rd_en`, `wr_en`, `busy` and `complete` become 0.
  - `rd_addr`, `wr_addr`, `wr_data` and `op` become 0.
  - This holds in any state. A frame in flight is abandoned and no further writes are issued.
- `start` accepted at edge 0. Then:
  - `rd_en`=1 with `rd_addr`=k in cycle k+1, for k=0..N-1.
  - `wr_en`=1 with `wr_addr`=k in cycle k+4. Fixed latency is 3 cycles from read to write for every `op`.
  - `busy`=1 in cycles 1..N+3.
  - `complete`=1 in cycle N+4 only, with `busy`=0 that cycle.
- The earliest next `start` is sampled in cycle N+5, in IDLE.
- `wr_en` is never high outside cycles 4..N+3. `rd_en` and `wr_en` overlap during READ.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with `start`=1 → all outputs 0 and no `rd_en`. Release `rst` with `start`=0 → the block stays idle.
- **Pass (`sel`=0):** use `IMG_W`=4, `IMG_H`=2 and source pixel[k]=10k.
  - Writes appear in cycles 4..11 with `wr_addr`=k and `wr_data`=10k.
  - `complete` pulses in cycle 12.
- **Invert and threshold:**
  - With `sel`=1, 0x30 → 0xCF.
  - With `sel`=2 and `THRESH`=128: 127 → 0x00, 128 → 0xFF, 255 → 0xFF.
- **Smooth (`sel`=3):** rows [0,40,80,200] and [200,80,40,0].
  - Row 0 writes 10, 40, 100, 170.
  - Row 1 writes 170, 100, 40, 10. The x=0 pixel of row 1 does not use the row-0 pixel.
- **Busy rules:** pulse `start` and toggle `sel` during cycle 5 → no restart and the frame result is unchanged. `start` held high through DONE → a second frame begins exactly at the IDLE sample in cycle N+5.
- **Reset mid-frame:** assert `rst` in cycle 6.
  - From cycle 7, `wr_en`, `rd_en` and `busy` are 0 and no `complete` occurs.
  - A subsequent `start` runs a full, correct frame.
